// File: rtl/answer_arbiter_pkg.sv
// Shared definitions for the answer arbiter: FSM states, player ids and
// default answer width.
package answer_arbiter_pkg;

  // Arbiter control states for one question round.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARMED = 3'd1,
    ST_HOLD  = 3'd2,
    ST_JUDGE = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  // Player identifiers as carried on ans_player.
  localparam logic PLAYER_A = 1'b0;
  localparam logic PLAYER_B = 1'b1;

  // Default width of a player's answer entry.
  localparam int unsigned DEFAULT_DATA_W = 3;

  // The opponent of a given player.
  function automatic logic other_player(input logic p);
    return ~p;
  endfunction

endpackage

// File: rtl/answer_arbiter_press_edge_detect.sv
// Registered rising-edge detector for a raw player load button. The history
// register updates every cycle regardless of arbiter state, so a button held
// across a state change never produces a late press.
module press_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  output logic press_o
);

  logic btn_q;

  // Track the previous button level; synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      btn_q <= 1'b0;
    end else begin
      btn_q <= btn_i;
    end
  end

  assign press_o = btn_i & ~btn_q;

endmodule

// File: rtl/answer_arbiter.sv
// Two-player answer arbiter: detects load presses, grants one winner per race
// with an alternating tie-break, offers the captured answer on a valid/ready
// handshake, applies lockouts on wrong verdicts and keeps one pending press.
module answer_arbiter
  import answer_arbiter_pkg::*;
#(
  parameter int unsigned DATA_W = DEFAULT_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              round_open,
  input  logic              load_A,
  input  logic              load_B,
  input  logic [DATA_W-1:0] In_A,
  input  logic [DATA_W-1:0] In_B,
  output logic              ans_valid,
  input  logic              ans_ready,
  output logic              ans_player,
  output logic [DATA_W-1:0] ans_data,
  input  logic              result_valid,
  input  logic              result_ok,
  output logic              lock_A,
  output logic              lock_B,
  output logic              round_won,
  output logic              round_dead
);

  state_e              state_q, state_d;
  logic                player_q, player_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                pend_v_q, pend_v_d;
  logic                pend_p_q, pend_p_d;
  logic [DATA_W-1:0]   pend_data_q, pend_data_d;
  logic                lock_a_q, lock_a_d;
  logic                lock_b_q, lock_b_d;
  logic                tie_q, tie_d;
  logic                won_q, won_d;
  logic                dead_q, dead_d;

  logic                press_a, press_b;
  logic                grant_a, grant_b;
  logic                tie_win;
  logic [DATA_W-1:0]   tie_win_data, tie_lose_data;
  logic                other_p;
  logic                other_press;
  logic                other_locked;
  logic [DATA_W-1:0]   other_data;
  logic                fill;

  press_edge_detect u_edge_a (
    .clk     (clk),
    .rst     (rst),
    .btn_i   (load_A),
    .press_o (press_a)
  );

  press_edge_detect u_edge_b (
    .clk     (clk),
    .rst     (rst),
    .btn_i   (load_B),
    .press_o (press_b)
  );

  // Presses only count from players that are not locked out.
  assign grant_a = press_a & ~lock_a_q;
  assign grant_b = press_b & ~lock_b_q;

  // Tie goes to whoever did not win the previous tie.
  assign tie_win       = other_player(tie_q);
  assign tie_win_data  = (tie_win == PLAYER_A) ? In_A : In_B;
  assign tie_lose_data = (tie_win == PLAYER_A) ? In_B : In_A;

  // The player not currently offered may fill an empty pending slot.
  assign other_p      = other_player(player_q);
  assign other_press  = (other_p == PLAYER_A) ? grant_a : grant_b;
  assign other_locked = (other_p == PLAYER_A) ? lock_a_q : lock_b_q;
  assign other_data   = (other_p == PLAYER_A) ? In_A : In_B;
  assign fill         = ~pend_v_q & other_press;

  // State and datapath registers; last tie winner starts at B so A wins first.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      player_q    <= PLAYER_A;
      data_q      <= '0;
      pend_v_q    <= 1'b0;
      pend_p_q    <= PLAYER_A;
      pend_data_q <= '0;
      lock_a_q    <= 1'b0;
      lock_b_q    <= 1'b0;
      tie_q       <= PLAYER_B;
      won_q       <= 1'b0;
      dead_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      player_q    <= player_d;
      data_q      <= data_d;
      pend_v_q    <= pend_v_d;
      pend_p_q    <= pend_p_d;
      pend_data_q <= pend_data_d;
      lock_a_q    <= lock_a_d;
      lock_b_q    <= lock_b_d;
      tie_q       <= tie_d;
      won_q       <= won_d;
      dead_q      <= dead_d;
    end
  end

  // Next-state, capture, pending, lockout and pulse logic.
  always_comb begin
    state_d     = state_q;
    player_d    = player_q;
    data_d      = data_q;
    pend_v_d    = pend_v_q;
    pend_p_d    = pend_p_q;
    pend_data_d = pend_data_q;
    lock_a_d    = lock_a_q;
    lock_b_d    = lock_b_q;
    tie_d       = tie_q;
    won_d       = 1'b0;
    dead_d      = 1'b0;

    if (!round_open) begin
      // Abort or closed round: clear everything except the tie history, so
      // the registers already hold reset values on the cycle IDLE is entered.
      state_d     = ST_IDLE;
      player_d    = PLAYER_A;
      data_d      = '0;
      pend_v_d    = 1'b0;
      pend_p_d    = PLAYER_A;
      pend_data_d = '0;
      lock_a_d    = 1'b0;
      lock_b_d    = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_ARMED;
        end

        ST_ARMED: begin
          if (grant_a && grant_b) begin
            player_d    = tie_win;
            data_d      = tie_win_data;
            pend_v_d    = 1'b1;
            pend_p_d    = other_player(tie_win);
            pend_data_d = tie_lose_data;
            tie_d       = tie_win;
            state_d     = ST_HOLD;
          end else if (grant_a) begin
            player_d = PLAYER_A;
            data_d   = In_A;
            state_d  = ST_HOLD;
          end else if (grant_b) begin
            player_d = PLAYER_B;
            data_d   = In_B;
            state_d  = ST_HOLD;
          end
        end

        ST_HOLD: begin
          if (fill) begin
            pend_v_d    = 1'b1;
            pend_p_d    = other_p;
            pend_data_d = other_data;
          end
          if (ans_ready) begin
            state_d = ST_JUDGE;
          end
        end

        ST_JUDGE: begin
          if (result_valid) begin
            // A press landing in the verdict cycle is not queued; the
            // routing decision uses the slot as it stood before the verdict.
            if (result_ok) begin
              won_d    = 1'b1;
              pend_v_d = 1'b0;
              state_d  = ST_DONE;
            end else begin
              if (player_q == PLAYER_A) begin
                lock_a_d = 1'b1;
              end else begin
                lock_b_d = 1'b1;
              end
              if (pend_v_q) begin
                player_d = pend_p_q;
                data_d   = pend_data_q;
                pend_v_d = 1'b0;
                state_d  = ST_HOLD;
              end else if (!other_locked) begin
                state_d = ST_ARMED;
              end else begin
                dead_d  = 1'b1;
                state_d = ST_DONE;
              end
            end
          end else if (fill) begin
            pend_v_d    = 1'b1;
            pend_p_d    = other_p;
            pend_data_d = other_data;
          end
        end

        ST_DONE: begin
          state_d = ST_DONE;
        end

        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  assign ans_valid  = (state_q == ST_HOLD);
  assign ans_player = player_q;
  assign ans_data   = data_q;
  assign lock_A     = lock_a_q;
  assign lock_B     = lock_b_q;
  assign round_won  = won_q;
  assign round_dead = dead_q;

endmodule

// File: tb/tb_answer_arbiter.sv
// Self-checking bench for answer_arbiter: expected offers are queued as
// presses are driven and compared when the handshake transfers them.
module tb_answer_arbiter;

  localparam int unsigned DW = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          round_open = 1'b0;
  logic          load_A = 1'b0;
  logic          load_B = 1'b0;
  logic [DW-1:0] In_A = '0;
  logic [DW-1:0] In_B = '0;
  logic          ans_valid;
  logic          ans_ready = 1'b0;
  logic          ans_player;
  logic [DW-1:0] ans_data;
  logic          result_valid = 1'b0;
  logic          result_ok = 1'b0;
  logic          lock_A, lock_B, round_won, round_dead;

  int n_tests = 0;
  int n_fail  = 0;

  logic [DW:0] exp_q[$];

  answer_arbiter #(.DATA_W(DW)) dut (
    .clk          (clk),
    .rst          (rst),
    .round_open   (round_open),
    .load_A       (load_A),
    .load_B       (load_B),
    .In_A         (In_A),
    .In_B         (In_B),
    .ans_valid    (ans_valid),
    .ans_ready    (ans_ready),
    .ans_player   (ans_player),
    .ans_data     (ans_data),
    .result_valid (result_valid),
    .result_ok    (result_ok),
    .lock_A       (lock_A),
    .lock_B       (lock_B),
    .round_won    (round_won),
    .round_dead   (round_dead)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic p, input logic [DW-1:0] d);
    exp_q.push_back({p, d});
  endtask

  task automatic accept();
    ans_ready = 1'b1;
    step();
    ans_ready = 1'b0;
  endtask

  task automatic verdict(input logic ok);
    result_valid = 1'b1;
    result_ok    = ok;
    step();
    result_valid = 1'b0;
    result_ok    = 1'b0;
  endtask

  task automatic open_round();
    round_open = 1'b1;
    step();
  endtask

  task automatic close_round();
    round_open = 1'b0;
    step();
  endtask

  // Scoreboard: each handshake transfer must match the next expected offer.
  always @(negedge clk) begin
    if (rst && ans_valid && ans_ready) begin
      check_eq("sb_nonempty", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
        logic [DW:0] e;
        e = exp_q.pop_front();
        check_eq("sb_player", ans_player, e[DW]);
        check_eq("sb_data", ans_data, e[DW-1:0]);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    // Reset
    rst = 1'b0;
    repeat (3) step();
    check_eq("rst_valid", ans_valid, 0);
    check_eq("rst_player", ans_player, 0);
    check_eq("rst_data", ans_data, 0);
    check_eq("rst_lockA", lock_A, 0);
    check_eq("rst_lockB", lock_B, 0);
    check_eq("rst_won", round_won, 0);
    check_eq("rst_dead", round_dead, 0);
    rst = 1'b1;
    step();

    // Single press, correct answer
    open_round();
    In_A = 3'd5; load_A = 1'b1; push_exp(1'b0, 3'd5);
    step();
    load_A = 1'b0;
    check_eq("single_valid", ans_valid, 1);
    check_eq("single_player", ans_player, 0);
    check_eq("single_data", ans_data, 5);
    accept();
    check_eq("single_drop", ans_valid, 0);
    verdict(1'b1);
    check_eq("single_won", round_won, 1);
    step();
    check_eq("single_won_pulse", round_won, 0);
    check_eq("single_no_reoffer", ans_valid, 0);
    close_round();

    // Tie round 1: A wins, wrong, B replayed, wrong -> dead
    open_round();
    In_A = 3'd2; In_B = 3'd6; load_A = 1'b1; load_B = 1'b1;
    push_exp(1'b0, 3'd2); push_exp(1'b1, 3'd6);
    step();
    load_A = 1'b0; load_B = 1'b0;
    check_eq("tie1_player", ans_player, 0);
    check_eq("tie1_data", ans_data, 2);
    accept();
    verdict(1'b0);
    check_eq("tie1_replay_valid", ans_valid, 1);
    check_eq("tie1_replay_player", ans_player, 1);
    check_eq("tie1_replay_data", ans_data, 6);
    check_eq("tie1_lockA", lock_A, 1);
    accept();
    verdict(1'b0);
    check_eq("tie1_dead", round_dead, 1);
    check_eq("tie1_lockB", lock_B, 1);
    step();
    check_eq("tie1_dead_pulse", round_dead, 0);
    close_round();
    check_eq("tie1_clr_lockA", lock_A, 0);
    check_eq("tie1_clr_lockB", lock_B, 0);

    // Tie round 2: B wins this time
    open_round();
    In_A = 3'd1; In_B = 3'd4; load_A = 1'b1; load_B = 1'b1;
    push_exp(1'b1, 3'd4); push_exp(1'b0, 3'd1);
    step();
    load_A = 1'b0; load_B = 1'b0;
    check_eq("tie2_player", ans_player, 1);
    check_eq("tie2_data", ans_data, 4);
    accept();
    verdict(1'b0);
    check_eq("tie2_replay_player", ans_player, 0);
    check_eq("tie2_replay_data", ans_data, 1);
    accept();
    verdict(1'b1);
    check_eq("tie2_won", round_won, 1);
    close_round();

    // Backpressure with changing switches
    open_round();
    In_A = 3'd3; load_A = 1'b1; push_exp(1'b0, 3'd3);
    step();
    load_A = 1'b0;
    for (int i = 0; i < 10; i++) begin
      In_A = DW'($urandom_range(0, 7));
      step();
      check_eq("bp_valid", ans_valid, 1);
      check_eq("bp_data", ans_data, 3);
    end
    accept();
    verdict(1'b1);
    close_round();

    // Lockout
    open_round();
    In_A = 3'd7; load_A = 1'b1; push_exp(1'b0, 3'd7);
    step();
    load_A = 1'b0;
    accept();
    verdict(1'b0);
    check_eq("lock_A_set", lock_A, 1);
    check_eq("lock_rearm_valid", ans_valid, 0);
    load_A = 1'b1;
    step();
    load_A = 1'b0;
    check_eq("lock_A_ignored", ans_valid, 0);
    step();
    In_B = 3'd2; load_B = 1'b1; push_exp(1'b1, 3'd2);
    step();
    load_B = 1'b0;
    check_eq("lock_B_player", ans_player, 1);
    check_eq("lock_B_valid", ans_valid, 1);
    accept();
    verdict(1'b0);
    check_eq("lock_dead", round_dead, 1);
    step();
    load_B = 1'b1;
    step();
    load_B = 1'b0;
    check_eq("done_ignore", ans_valid, 0);
    check_eq("done_lockA", lock_A, 1);
    check_eq("done_lockB", lock_B, 1);
    close_round();
    check_eq("lock_clrA", lock_A, 0);
    check_eq("lock_clrB", lock_B, 0);

    // Pending fill during HOLD
    open_round();
    In_A = 3'd1; load_A = 1'b1; push_exp(1'b0, 3'd1);
    step();
    load_A = 1'b0;
    In_B = 3'd5; load_B = 1'b1; push_exp(1'b1, 3'd5);
    step();
    load_B = 1'b0;
    accept();
    verdict(1'b0);
    check_eq("pend_valid", ans_valid, 1);
    check_eq("pend_player", ans_player, 1);
    check_eq("pend_data", ans_data, 5);
    accept();
    verdict(1'b1);
    check_eq("pend_won", round_won, 1);
    close_round();

    // Abort during HOLD
    open_round();
    In_A = 3'd6; load_A = 1'b1;
    step();
    load_A = 1'b0;
    check_eq("abort_pre_valid", ans_valid, 1);
    round_open = 1'b0;
    step();
    check_eq("abort_valid", ans_valid, 0);
    check_eq("abort_data", ans_data, 0);
    check_eq("abort_player", ans_player, 0);
    step();

    // Held button before round opens
    load_B = 1'b1;
    step();
    open_round();
    step();
    step();
    check_eq("held_no_offer", ans_valid, 0);
    load_B = 1'b0;
    step();
    In_B = 3'd3; load_B = 1'b1; push_exp(1'b1, 3'd3);
    step();
    load_B = 1'b0;
    check_eq("held_repress_valid", ans_valid, 1);
    check_eq("held_repress_player", ans_player, 1);
    check_eq("held_repress_data", ans_data, 3);
    accept();
    verdict(1'b1);
    close_round();

    step();
    check_eq("sb_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
